// File: rtl/multdiv_iter.sv
// Iterative signed multiplier/divider: shift-add multiply, restoring divide.
// Define MULTDIV_REM_EN to add the data_remainder output.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
`ifdef MULTDIV_REM_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             bzero_q;
  logic             ovf_q;

  logic             start;
  logic             last;
  logic             go_mult;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] min_val;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign go_mult = ctrl_MULT;
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign min_val = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // One iteration step; hi holds partial product / partial remainder.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   hi_n;
  logic [WIDTH-1:0] lo_n;

  always_comb begin
    sum   = lo_q[0] ? hi_q + {1'b0, dsr_q} : hi_q;
    shf   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial = shf - {1'b0, dsr_q};
    hi_n  = {1'b0, sum[WIDTH:1]};
    lo_n  = {sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (trial[WIDTH]) begin
        hi_n = shf;
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_n = trial;
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  logic [2*WIDTH-1:0] mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     top;
  logic               mult_exc;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   res_d;
  logic               exc_d;

  always_comb begin
    mag      = {hi_q[WIDTH-1:0], lo_q};
    prod     = neg_res_q ? -mag : mag;
    top      = prod[2*WIDTH-1:WIDTH-1];
    mult_exc = !((&top) | ~(|top));
    quot     = neg_res_q ? -lo_q : lo_q;
    res_d    = prod[WIDTH-1:0];
    exc_d    = mult_exc;
    if (is_div_q) begin
      if (bzero_q) begin
        res_d = '0;
        exc_d = 1'b1;
      end else begin
        res_d = quot;
        exc_d = ovf_q;
      end
    end
  end

`ifdef MULTDIV_REM_EN
  logic             neg_rem_q;
  logic [WIDTH-1:0] rem_d;

  always_comb begin
    rem_d = '0;
    if (is_div_q && !bzero_q) begin
      rem_d = neg_rem_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_rem_q      <= 1'b0;
      data_remainder <= '0;
    end else begin
      if (start) begin
        neg_rem_q <= data_operandA[WIDTH-1];
      end
      if (state_q == DONE && !start) begin
        data_remainder <= rem_d;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (start) state_d = RUN;
        else if (last) state_d = DONE;
      end
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      dsr_q          <= '0;
      is_div_q       <= 1'b0;
      neg_res_q      <= 1'b0;
      bzero_q        <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_busy      <= start | (state_q != IDLE);
      data_resultRDY <= (state_q == DONE) && !start;
      if (start) begin
        cnt_q     <= '0;
        hi_q      <= '0;
        lo_q      <= go_mult ? b_mag : a_mag;
        dsr_q     <= go_mult ? a_mag : b_mag;
        is_div_q  <= !go_mult;
        neg_res_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        bzero_q   <= (data_operandB == '0);
        ovf_q     <= (data_operandA == min_val) && (&data_operandB);
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CW'(1);
        hi_q  <= hi_n;
        lo_q  <= lo_n;
      end
      if (state_q == DONE && !start) begin
        data_result    <= res_d;
        data_exception <= exc_d;
      end
    end
  end

endmodule
